// File: rtl/bf16_pkg.sv
// Shared bf16 types, constants and classification helpers.
// Used by the accumulator stream and its adder datapath.
package bf16_pkg;

    localparam int E = 8;
    localparam int M = 7;

    typedef struct packed {
        logic         s;
        logic [E-1:0] e;
        logic [M-1:0] m;
    } bf16_t;

    localparam logic [E-1:0] EXP_SPECIAL = 8'hFF;
    localparam bf16_t BF16_ZERO = '{s: 1'b0, e: 8'h00, m: 7'h00};
    localparam bf16_t BF16_QNAN = '{s: 1'b0, e: 8'hFF, m: 7'h40};

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_e;

    function automatic logic is_zero(input bf16_t v);
        return v.e == '0;
    endfunction

    function automatic logic is_special(input bf16_t v);
        return v.e == EXP_SPECIAL;
    endfunction

endpackage

// File: rtl/bf16_acc_stream_if.sv
// Element input stream and result output stream of the accumulator.
// The slave view is the accumulator, the master view its environment.
interface bf16_acc_stream_if
    import bf16_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             valid_i;
    logic             ready_o;
    logic             s_i;
    logic [E-1:0]     e_i;
    logic [M-1:0]     m_i;
    logic             last_i;
    logic             valid_o;
    logic             ready_i;
    logic             s_o;
    logic [E-1:0]     e_o;
    logic [M-1:0]     m_o;
    logic [CNT_W-1:0] cnt_o;
    logic             nan_o;

    modport slave (
        input  valid_i, s_i, e_i, m_i, last_i, ready_i,
        output ready_o, valid_o, s_o, e_o, m_o, cnt_o, nan_o
    );

    modport master (
        output valid_i, s_i, e_i, m_i, last_i, ready_i,
        input  ready_o, valid_o, s_o, e_o, m_o, cnt_o, nan_o
    );
endinterface

// File: rtl/bf16_add.sv
// Combinational bf16 adder, round toward zero, subnormals flushed.
// Guard/round/sticky bits keep truncation exact on cancellation.
module bf16_add
    import bf16_pkg::*;
(
    input  bf16_t a_i,
    input  bf16_t b_i,
    output bf16_t y_o
);
    bf16_t        big;
    bf16_t        sml;
    logic [E-1:0] diff;
    logic [10:0]  ma_x;
    logic [10:0]  mb_x;
    logic [10:0]  mask;
    logic [10:0]  al;
    logic [11:0]  sum;
    logic [11:0]  nrm;
    logic [3:0]   sh;

    always_comb begin
        if ({a_i.e, a_i.m} >= {b_i.e, b_i.m}) begin
            big = a_i;
            sml = b_i;
        end else begin
            big = b_i;
            sml = a_i;
        end
        diff = big.e - sml.e;
        ma_x = {1'b1, big.m, 3'b000};
        mb_x = {1'b1, sml.m, 3'b000};
        mask = ~(11'h7FF << diff[3:0]);
        if (diff > 8'd10) begin
            al = 11'd1;
        end else begin
            al = (mb_x >> diff[3:0]) | {10'd0, |(mb_x & mask)};
        end
        if (big.s ^ sml.s) begin
            sum = {1'b0, ma_x} - {1'b0, al};
        end else begin
            sum = {1'b0, ma_x} + {1'b0, al};
        end
        sh = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (sum[i]) sh = 4'(10 - i);
        end
        nrm = sum << sh;

        y_o = BF16_ZERO;
        if (is_special(a_i) || is_special(b_i)) begin
            y_o = BF16_QNAN;
        end else if (is_zero(a_i)) begin
            y_o = b_i;
        end else if (is_zero(b_i)) begin
            y_o = a_i;
        end else if (sum == '0) begin
            y_o = BF16_ZERO;
        end else if (sum[11]) begin
            // Overflow truncates to the largest finite value
            if (big.e == 8'hFE) begin
                y_o = '{s: big.s, e: 8'hFE, m: 7'h7F};
            end else begin
                y_o = '{s: big.s, e: big.e + 8'd1, m: sum[10:4]};
            end
        end else if ({1'b0, big.e} <= {5'd0, sh}) begin
            y_o = BF16_ZERO;
        end else begin
            y_o = '{s: big.s, e: big.e - {4'd0, sh}, m: nrm[9:3]};
        end
    end
endmodule

// File: rtl/bf16_acc_stream.sv
// Streaming bf16 vector accumulator: sums elements up to last_i and
// emits one result plus saturating element count per vector.
module bf16_acc_stream
    import bf16_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic                  clk,
    input  logic                  nreset,
    bf16_acc_stream_if.slave      bus
);
    state_e           state_q, state_d;
    bf16_t            acc_q, acc_d;
    logic             acc_zero_q, acc_zero_d;
    logic             nan_q, nan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    bf16_t            elem;
    bf16_t            sum;
    bf16_t            res;
    logic             ready;
    logic             acc_en;
    logic             fresh;
    logic             normal;
    logic             az_b;

    assign elem   = '{s: bus.s_i, e: bus.e_i, m: bus.m_i};
    assign ready  = (state_q != DONE) | bus.ready_i;
    assign acc_en = bus.valid_i & ready;
    assign fresh  = (state_q == IDLE) | (state_q == DONE);
    assign normal = ~is_zero(elem) & ~is_special(elem);
    assign az_b   = fresh | acc_zero_q;

    bf16_add u_add (
        .a_i (acc_q),
        .b_i (elem),
        .y_o (sum)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            acc_q      <= BF16_ZERO;
            acc_zero_q <= 1'b1;
            nan_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_zero_q <= acc_zero_d;
            nan_q      <= nan_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        acc_zero_d = acc_zero_q;
        nan_d      = nan_q;
        cnt_d      = cnt_q;
        if (acc_en) begin
            // A fresh vector starts from a cleared accumulator
            acc_d      = fresh ? BF16_ZERO : acc_q;
            acc_zero_d = az_b;
            nan_d      = fresh ? 1'b0 : nan_q;
            if (fresh) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            unique case (1'b1)
                is_special(elem): nan_d = 1'b1;
                is_zero(elem):    ;
                normal & az_b: begin
                    acc_d      = elem;
                    acc_zero_d = 1'b0;
                end
                normal & ~az_b:   acc_d = sum;
                default:          ;
            endcase
        end
        unique case (state_q)
            IDLE, ACC: begin
                if (acc_en) state_d = bus.last_i ? DONE : ACC;
            end
            DONE: begin
                if (acc_en) begin
                    state_d = bus.last_i ? DONE : ACC;
                end else if (bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res = acc_q;
        if (nan_q) begin
            res = BF16_QNAN;
        end else if (acc_zero_q) begin
            res = BF16_ZERO;
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = state_q == DONE;
    assign bus.s_o     = res.s;
    assign bus.e_o     = res.e;
    assign bus.m_o     = res.m;
    assign bus.cnt_o   = cnt_q;
    assign bus.nan_o   = nan_q;
endmodule

// File: tb/tb_bf16_acc_stream.sv
// Directed bench for bf16_acc_stream with hand-computed results.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_bf16_acc_stream;
    logic clk;
    logic nreset;
    int   n_chk;
    int   n_pass;

    bf16_acc_stream_if #(.CNT_W(8)) tb_if ();

    bf16_acc_stream #(.CNT_W(8)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (tb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] res16();
        return {tb_if.s_o, tb_if.e_o, tb_if.m_o};
    endfunction

    task automatic put(input logic [15:0] v, input logic l);
        tb_if.valid_i = 1'b1;
        {tb_if.s_i, tb_if.e_i, tb_if.m_i} = v;
        tb_if.last_i = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tb_if.valid_i = 1'b0;
        tb_if.last_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input logic [15:0] v,
                             input int cnt, input logic nan);
        check({tag, ".valid"}, 32'(tb_if.valid_o), 32'd1);
        check({tag, ".data"}, 32'(res16()), 32'(v));
        check({tag, ".cnt"}, 32'(tb_if.cnt_o), 32'(cnt));
        check({tag, ".nan"}, 32'(tb_if.nan_o), 32'(nan));
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        nreset = 1'b0;
        tb_if.valid_i = 1'b0;
        tb_if.s_i     = 1'b0;
        tb_if.e_i     = '0;
        tb_if.m_i     = '0;
        tb_if.last_i  = 1'b0;
        tb_if.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(tb_if.valid_o), 32'd0);
        check("rst.ready", 32'(tb_if.ready_o), 32'd1);
        check("rst.data", 32'(res16()), 32'd0);
        check("rst.cnt", 32'(tb_if.cnt_o), 32'd0);
        check("rst.nan", 32'(tb_if.nan_o), 32'd0);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        put(16'h3F80, 1'b1);
        check_res("one", 16'h3F80, 1, 1'b0);
        idle();
        check("one.idle", 32'(tb_if.valid_o), 32'd0);

        put(16'h3F80, 1'b0);
        put(16'h3F80, 1'b0);
        put(16'h4000, 1'b1);
        check_res("sum4", 16'h4080, 3, 1'b0);
        idle();

        put(16'h0000, 1'b0);
        put(16'h0001, 1'b0);
        put(16'h3FC0, 1'b1);
        check_res("bypass", 16'h3FC0, 3, 1'b0);
        idle();

        put(16'h0000, 1'b1);
        check_res("zero", 16'h0000, 1, 1'b0);
        idle();

        put(16'h3F80, 1'b0);
        put(16'h7F80, 1'b0);
        put(16'h3F80, 1'b1);
        check_res("inf", 16'h7FC0, 3, 1'b1);
        idle();
        put(16'h3F80, 1'b1);
        check_res("after_nan", 16'h3F80, 1, 1'b0);
        idle();

        // 2.0 - 2^-8 truncates to 1.9921875
        put(16'h4000, 1'b0);
        put(16'hBB80, 1'b1);
        check_res("sub_rtz", 16'h3FFF, 2, 1'b0);
        idle();

        put(16'h3F80, 1'b0);
        put(16'hBF80, 1'b1);
        check_res("cancel", 16'h0000, 2, 1'b0);
        idle();

        tb_if.ready_i = 1'b0;
        put(16'h3F80, 1'b0);
        put(16'h4040, 1'b1);
        tb_if.valid_i = 1'b1;
        {tb_if.s_i, tb_if.e_i, tb_if.m_i} = 16'h4000;
        tb_if.last_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_res("hold", 16'h4080, 2, 1'b0);
            check("hold.ready", 32'(tb_if.ready_o), 32'd0);
            @(posedge clk);
            #1;
        end
        tb_if.ready_i = 1'b1;
        #1;
        check("release.ready", 32'(tb_if.ready_o), 32'd1);
        @(posedge clk);
        #1;
        check_res("b2b", 16'h4000, 1, 1'b0);
        idle();
        check("b2b.idle", 32'(tb_if.valid_o), 32'd0);

        for (int k = 0; k < 299; k++) put(16'h0000, 1'b0);
        put(16'h3F80, 1'b1);
        check_res("sat", 16'h3F80, 255, 1'b0);
        idle();

        put(16'h3F80, 1'b0);
        put(16'h3F80, 1'b0);
        tb_if.valid_i = 1'b0;
        #2;
        nreset = 1'b0;
        #1;
        check("arst.valid", 32'(tb_if.valid_o), 32'd0);
        check("arst.ready", 32'(tb_if.ready_o), 32'd1);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        put(16'h4000, 1'b1);
        check_res("post_rst", 16'h4000, 1, 1'b0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bf16_acc_stream.md
Name: bf16_acc_stream

Overview:
- Sequential vector accumulator around the combinational bf16 adder (`bf16_add`).
- Consumes a valid/ready stream of bf16 operands and sums each vector, with vector boundaries marked by `last_i`.
- Presents one bf16 result plus an element count per vector on a valid/ready output port.
- Feeds `bf16_add` directly: the accumulator register is operand a, the incoming element is operand b.

Parameters:
- E, 8, exponent width (fixed to bf16).
- M, 7, stored mantissa width (fixed to bf16).
- CNT_W, 8, width of the element counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock, all state on rising edge
- nreset  input  1  asynchronous active-low reset
- valid_i  input  1  input element valid
- ready_o  output  1  block can accept an element this cycle
- s_i  input  1  element sign
- e_i  input  E  element exponent
- m_i  input  M  element mantissa
- last_i  input  1  element is final of its vector
- valid_o  output  1  result valid
- ready_i  input  1  downstream accepts result
- s_o  output  1  result sign
- e_o  output  E  result exponent
- m_o  output  M  result mantissa
- cnt_o  output  CNT_W  elements accepted in this vector (saturating)
- nan_o  output  1  result forced to NaN because an inf/NaN was seen

Behaviour:
- Clock and reset: one clock, `clk`. Reset `nreset` is asynchronous and active-low.
- Reset values: state=IDLE, acc={0,0,0}, acc_zero=1, nan=0, cnt=0.
  - Outputs under reset: valid_o=0, ready_o=1, s_o/e_o/m_o=0, cnt_o=0, nan_o=0.
- Accept event: acc_en = valid_i & ready_o.
- ready_o = (state != DONE) | ready_i. This lets the first element of the next vector be taken in the same cycle the result handshakes.
- Element classification:
  - zero: e_i == 0; subnormals are flushed to zero.
  - special: e_i == 8'hFF.
  - normal: all other exponents.
- Accumulate rule on acc_en:
  - special: nan <= 1; acc is unchanged.
  - zero: acc is unchanged.
  - normal with acc_zero=1: acc <= {s_i,e_i,m_i} and acc_zero <= 0. The adder is bypassed.
  - normal with acc_zero=0: acc <= bf16_add(acc, element), used as-is (round toward zero, no extra saturation here).
  - cnt <= (fresh vector ? 1 : sat_inc(cnt)) for every accepted element, whatever its class.
- Fresh vector: the element accepted in IDLE, or in DONE during the output handshake. On a fresh vector, acc_zero, acc and nan are re-initialised before the accumulate rule is applied. A fresh special element sets nan=1.
- State machine:
  - IDLE: on acc_en, go to DONE if last_i, else to ACC.
  - ACC: on acc_en with last_i, go to DONE; otherwise stay.
  - DONE: valid_o=1.
    - ready_i=1 and no acc_en: go to IDLE.
    - ready_i=1 and acc_en: start a fresh vector, then go to DONE if last_i, else to ACC.
    - ready_i=0: hold state.
- Output contents in DONE:
  - nan=1: {s_o,e_o,m_o} = {0, 8'hFF, 7'h40}, nan_o=1.
  - acc_zero=1: all-zero result (+0).
  - otherwise: acc.
- Stability: outputs are registered and held stable while valid_o & ~ready_i. In non-DONE states the data outputs hold their last value; they are don't-care for checking.
- Latency: result is valid on the cycle after the `last_i` element is accepted.
- Throughput: one element per cycle; zero bubble between vectors when ready_i=1.
- Counter saturation: cnt sticks at 2^CNT_W-1 and never wraps.
- Reset asserted mid-vector: the partial sum is discarded. After release the block is in IDLE; the next element starts a fresh vector.
- valid_i with ready_o=0 (DONE & ~ready_i): the element is not consumed, and the upstream must hold it.

Decomposition:
- Shared package bf16_pkg holds:
  - E/M constants;
  - a bf16 struct type {s,e,m};
  - constants BF16_ZERO, BF16_QNAN (0x7FC0), EXP_SPECIAL (8'hFF);
  - helper functions is_zero and is_special.
- One sub-module: instance of `bf16_add` for the adder datapath.
- Element classification, FSM and counter stay in bf16_acc_stream.

Test Plan:
- Single element 1.0 (0,7F,00) with last_i=1 -> next cycle valid_o=1, result 0x3F80, cnt_o=1, nan_o=0.
- Vector 1.0, 1.0, 2.0 (0x3F80, 0x3F80, 0x4000), last on third element -> result 0x4080 (4.0), cnt_o=3.
- Vector 0x0000, 0x0001 (subnormal), 0x3FC0 -> result 0x3FC0 (1.5, loaded via bypass), cnt_o=3. Vector of only 0x0000 with last -> result 0x0000, cnt_o=1.
- Vector 0x3F80, 0x7F80 (+inf), 0x3F80 -> result 0x7FC0, nan_o=1, cnt_o=3. The following vector 0x3F80 -> nan_o=0, result 0x3F80.
- Backpressure and back-to-back:
  - Hold ready_i=0 for 5 cycles in DONE -> outputs stable, ready_o=0.
  - Then ready_i=1 with valid_i=1, 0x4000, last_i=1 in the same cycle -> next result 0x4000, cnt_o=1, with no idle cycle in between.
- Reset mid-vector: accept 0x3F80, 0x3F80, then assert nreset asynchronously between edges -> valid_o=0, ready_o=1 immediately. After release, a vector with 0x4000 and last_i=1 gives 0x4000, cnt_o=1.
